// File: rtl/comparator2_3.sv
// comparator2_3: unsigned window comparator on input a.
//   out       - combinational, 1 iff LO <= a <= HI (bounds inclusive)
//   out_q     - out delayed by one clock
//   out_rise  - one-cycle pulse after the first edge that samples a match
//               following a non-match
//   hit_count - saturating count of edges that sampled out=1; clr zeroes it
// All registered state uses a synchronous active-low reset.
module comparator2_3 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LO    = 2,
  parameter int unsigned HI    = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             clr,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic [CNT_W-1:0] hit_count
);

  // Largest value a can hold, computed wide so WIDTH up to 63 is safe.
  localparam longint unsigned MAX_V = (64'd1 << WIDTH) - 64'd1;

  // An inverted window, or a lower bound above anything a can represent,
  // can never match.
  localparam bit EMPTY = (LO > HI) || (64'(LO) > MAX_V);

  // Bounds clipped into the representable range of a.
  localparam logic [WIDTH-1:0] LO_C = (64'(LO) > MAX_V) ? WIDTH'(MAX_V) : WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_C = (64'(HI) > MAX_V) ? WIDTH'(MAX_V) : WIDTH'(HI);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Window decode. A bound sitting at the edge of the range of a is always
  // satisfied, so its compare is dropped rather than left as a constant-true
  // unsigned comparison.
  generate
    if (EMPTY) begin : g_empty
      assign out = 1'b0;
    end else begin : g_window
      logic ge_lo;
      logic le_hi;

      if (LO_C == '0) begin : g_lo_open
        assign ge_lo = 1'b1;
      end else begin : g_lo_cmp
        assign ge_lo = (a >= LO_C);
      end

      if (HI_C == '1) begin : g_hi_open
        assign le_hi = 1'b1;
      end else begin : g_hi_cmp
        assign le_hi = (a <= HI_C);
      end

      assign out = ge_lo & le_hi;
    end
  endgenerate

  // Registered match, rising-edge pulse and saturating hit counter.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge value of out_q; a blocking update of out_q would make out_rise
  // compare out against itself and never pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is sampled only on the clock edge; nothing here may
      // appear in the sensitivity list besides clk.
      out_q     <= 1'b0;
      out_rise  <= 1'b0;
      hit_count <= '0;
    end else begin
      out_q    <= out;
      out_rise <= out & ~out_q;
      if (clr) begin
        hit_count <= '0;
      end else if (out && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator2_3.sv
// Testbench for comparator2_3. Stimulus pushes the expected registered
// outputs into a scoreboard queue; a monitor pops and compares one entry
// one time unit after each rising edge. Combinational out is checked inline.
module tb_comparator2_3;

  typedef struct {
    logic       q;
    logic       rise;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0;
  logic       clr = 1'b0;

  logic       out, out_q, out_rise;
  logic [7:0] hit_count;

  // Extra instances for parameter overrides: shifted window, inverted
  // window and a window whose upper bound must be clipped.
  logic       out_mid, out_q_mid, out_rise_mid;
  logic [7:0] hit_count_mid;
  logic       out_inv, out_q_inv, out_rise_inv;
  logic [7:0] hit_count_inv;
  logic       out_clip, out_q_clip, out_rise_clip;
  logic [7:0] hit_count_clip;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  comparator2_3 u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .clr(clr),
    .out(out), .out_q(out_q), .out_rise(out_rise), .hit_count(hit_count)
  );

  comparator2_3 #(.WIDTH(4), .LO(5), .HI(9), .CNT_W(8)) u_mid (
    .clk(clk), .rst_n(rst_n), .a(a), .clr(clr),
    .out(out_mid), .out_q(out_q_mid), .out_rise(out_rise_mid),
    .hit_count(hit_count_mid)
  );

  comparator2_3 #(.WIDTH(4), .LO(9), .HI(5), .CNT_W(8)) u_inv (
    .clk(clk), .rst_n(rst_n), .a(a), .clr(clr),
    .out(out_inv), .out_q(out_q_inv), .out_rise(out_rise_inv),
    .hit_count(hit_count_inv)
  );

  comparator2_3 #(.WIDTH(4), .LO(12), .HI(40), .CNT_W(8)) u_clip (
    .clk(clk), .rst_n(rst_n), .a(a), .clr(clr),
    .out(out_clip), .out_q(out_q_clip), .out_rise(out_rise_clip),
    .hit_count(hit_count_clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, out is checked
  // immediately, and the registered outputs expected after the next rising
  // edge are queued for the monitor.
  task automatic step(input logic [3:0] va, input logic vclr, input logic vrst,
                      input logic e_out, input logic e_q, input logic e_rise,
                      input logic [7:0] e_cnt);
    exp_t e;
    @(negedge clk);
    a     = va;
    clr   = vclr;
    rst_n = vrst;
    e.q    = e_q;
    e.rise = e_rise;
    e.cnt  = e_cnt;
    sb.push_back(e);
    #1;
    check("out", 32'(out), 32'(e_out));
  endtask

  // Monitor: compare registered outputs one time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_q", 32'(out_q), 32'(e.q));
        check("out_rise", 32'(out_rise), 32'(e.rise));
        check("hit_count", 32'(hit_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [7:0] e_cnt;
    int         budget;

    // Sweep every a with reset held; out must still track a.
    #2;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      #1;
      check("sweep_default", 32'(out), 32'((i == 2) || (i == 3)));
      check("sweep_lo5_hi9", 32'(out_mid), 32'((i >= 5) && (i <= 9)));
      check("sweep_lo9_hi5", 32'(out_inv), 32'd0);
      check("sweep_clip", 32'(out_clip), 32'(i >= 12));
    end

    // Clean reset edge.
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Non-match for two edges, then a=2 for three edges.
    step(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
    step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);

    // Non-match holds the count and drops out_q.
    step(4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);

    // Count up to 10 with a=2; first edge is a fresh rise.
    step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4);
    for (int i = 5; i <= 10; i++) begin
      step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(i));
    end

    // clr beats a simultaneous match, counting restarts next edge.
    step(4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    step(4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);

    // a=3 for 300 edges: count climbs from 1 and pins at 255.
    for (int i = 1; i <= 300; i++) begin
      e_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      step(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, e_cnt);
    end

    // Bring the count to exactly 40 with out_q=1.
    step(4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 40; i++) begin
      step(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(i));
    end

    // Mid-run reset while matching: registers clear, out stays 1.
    step(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    // Released: counting resumes from 0 and the match reads as a new rise.
    step(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    step(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);

    // Reset beats clr and a match together.
    step(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    step(4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

    // Drain the scoreboard within a bounded number of cycles.
    budget = 0;
    while ((sb.size() > 0) && (budget < 20)) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator2_3.md
COMPARATOR2_3 -- requirements
Module: comparator2_3

Interface
REQ-001 Parameter WIDTH, default 4: bit width of input a.
REQ-002 Parameter LO, default 2: lower bound of the match range, unsigned, inclusive.
REQ-003 Parameter HI, default 3: upper bound of the match range, unsigned, inclusive.
REQ-004 Parameter CNT_W, default 8: bit width of hit_count.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all registered state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 a  input  WIDTH  unsigned value under test.
REQ-009 clr  input  1  synchronous clear of hit_count, active-high.
REQ-010 out  output  1  combinational match flag, 1 iff LO <= a <= HI.
REQ-011 out_q  output  1  out registered by one clock.
REQ-012 out_rise  output  1  one-cycle pulse on each 0->1 transition of the match.
REQ-013 hit_count  output  CNT_W  saturating count of clock edges sampled with out=1.

Function
REQ-014 out SHALL be purely combinational from a, with no dependence on clk, rst_n or clr, and SHALL settle within the same delta/timestep as a changes.
- With defaults: out=1 for a=2 and a=3; out=0 for all other a in 0..15.
REQ-015 out SHALL be a known 0/1 for every fully known a.
- Comparison SHALL be unsigned, with both bounds inclusive.
REQ-016 If LO > HI, out SHALL be constant 0; if LO or HI exceeds 2**WIDTH-1, the effective bound SHALL be clipped to the representable range.
REQ-017 On each rising clk edge with rst_n=1, out_q SHALL take the value of out.
REQ-018 On each rising clk edge with rst_n=1, out_rise SHALL take out & ~out_q.
- Result: out_rise is high for exactly one cycle after the first edge that samples a match following a non-match.
REQ-019 On each rising clk edge with rst_n=1 and clr=1, hit_count SHALL become 0.
- clr wins over a simultaneous match; that match is not counted.
REQ-020 On each rising clk edge with rst_n=1, clr=0 and out=1, hit_count SHALL increment by 1, saturating at 2**CNT_W-1 (255 with defaults) with no wrap.
REQ-021 On each rising clk edge with rst_n=1, clr=0 and out=0, hit_count SHALL hold its value.
REQ-022 Latency: out 0 cycles; out_q, out_rise and hit_count 1 cycle after a is sampled.

Reset
REQ-023 On a rising clk edge with rst_n=0, the following SHALL be 0:
- out_q
- out_rise
- hit_count
REQ-024 Reset SHALL take priority over clr and over a match.
REQ-025 out SHALL keep tracking a combinationally while rst_n=0.
REQ-026 rst_n asserted mid-operation SHALL clear all registered outputs at the next edge regardless of prior state.
- Counting resumes from 0 on the first edge with rst_n=1.
REQ-027 Registered outputs SHALL be undefined until the first clocked reset; no asynchronous behaviour is permitted.

Verification
REQ-028 Sweep a=0..15 (defaults), 1 ns apart -> out=1 only at a=2 and a=3; zero mismatches versus (a==2)|(a==3).
REQ-029 After reset, a=5 for 2 edges, then a=2 for 3 edges ->
- out_rise=1 for exactly the cycle after the first a=2 edge
- out_q=1 from that edge onward
- hit_count=3
REQ-030 a=3 held for 300 edges, clr=0 -> hit_count saturates and stays at 255.
REQ-031 hit_count=10, a=2, clr=1 for one edge -> hit_count=0 that edge; counts 1 on the next edge with clr=0.
REQ-032 rst_n=0 for one edge while a=3, hit_count=40, out_q=1 ->
- out_q=0, out_rise=0, hit_count=0 after the edge
- out=1 throughout
REQ-033 Parameter override LO=5, HI=9, sweep 0..15 -> out=1 exactly for a=5..9; LO=9, HI=5 -> out=0 for all a.
